// File: rtl/rca_pkg.sv
// Shared width and word type for the ripple-carry adder slice.
package rca_pkg;

  localparam int unsigned RCA_WIDTH = 8;

  typedef logic [RCA_WIDTH-1:0] rca_word_t;

endpackage : rca_pkg

// File: rtl/rca_8bit_full_adder.sv
// One-bit full adder cell; the building block of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/rca_8bit.sv
// Ripple-carry adder with a single registered output stage.
// Define RCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module rca_8bit
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Carry ripples strictly from bit 0 upward, no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  // Result register: loads only on valid operands, so idle inputs never leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
`ifdef RCA_OVERFLOW_EN
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule : rca_8bit

// File: tb/tb_rca_8bit.sv
// Self-checking bench for rca_8bit: directed cases plus a random sweep against an arithmetic model.
module tb_rca_8bit;
  import rca_pkg::*;

  logic      clk;
  logic      rst;
  rca_word_t a;
  rca_word_t b;
  logic      cin;
  logic      in_valid;
  logic      cout;
  rca_word_t sum;
  logic      out_valid;
`ifdef RCA_OVERFLOW_EN
  logic      ovf;
`endif

  int errors = 0;
  int checks = 0;

  rca_word_t exp_sum;
  logic      exp_cout;
  logic      exp_valid;
  logic      exp_ovf;

  rca_8bit #(.WIDTH(RCA_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .cout      (cout),
    .sum       (sum),
`ifdef RCA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare all outputs.
  task automatic cycle(input logic r, input rca_word_t ta, input rca_word_t tb,
                       input logic tc, input logic tv);
    logic [8:0] full;
    @(negedge clk);
    rst = r; a = ta; b = tb; cin = tc; in_valid = tv;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sum = '0; exp_cout = 1'b0; exp_valid = 1'b0; exp_ovf = 1'b0;
    end else begin
      exp_valid = tv;
      if (tv) begin
        full     = 9'(ta) + 9'(tb) + 9'(tc);
        exp_sum  = full[7:0];
        exp_cout = full[8];
        exp_ovf  = ($signed(ta) + $signed(tb) + $signed({1'b0, tc}) > 127) ||
                   ($signed(ta) + $signed(tb) + $signed({1'b0, tc}) < -128);
      end
    end
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("cout", 32'(cout), 32'(exp_cout));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
`ifdef RCA_OVERFLOW_EN
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_valid = 1'b0; exp_ovf = 1'b0;

    // Reset wins over valid operands.
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("rst_sum", 32'(sum), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'h0);

    cycle(1'b0, 8'h3F, 8'h55, 1'b0, 1'b1);
    chk("d_94_sum", 32'(sum), 32'h94);
    chk("d_94_cout", 32'(cout), 32'h0);
`ifdef RCA_OVERFLOW_EN
    chk("d_94_ovf", 32'(ovf), 32'h1);
`endif

    // Idle cycles hold the result, even with unknown operands.
    cycle(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    chk("hold_sum", 32'(sum), 32'h94);
    chk("hold_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 8'hxx, 8'hxx, 1'bx, 1'b0);
    chk("hold_x_sum", 32'(sum), 32'h94);

    cycle(1'b0, 8'hA7, 8'h7D, 1'b0, 1'b1);
    chk("d_24_sum", 32'(sum), 32'h24);
    chk("d_24_cout", 32'(cout), 32'h1);
    cycle(1'b0, 8'hB2, 8'h95, 1'b0, 1'b1);
    chk("d_47_sum", 32'(sum), 32'h47);
    chk("d_47_cout", 32'(cout), 32'h1);
`ifdef RCA_OVERFLOW_EN
    chk("d_47_ovf", 32'(ovf), 32'h1);
`endif

    cycle(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("ripple_sum", 32'(sum), 32'h00);
    chk("ripple_cout", 32'(cout), 32'h1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("cin_sum", 32'(sum), 32'h01);
    chk("cin_cout", 32'(cout), 32'h0);
    cycle(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("max_sum", 32'(sum), 32'hFF);
    chk("max_cout", 32'(cout), 32'h1);

    // Mid-stream reset drops the in-flight operands.
    cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    chk("mid_rst_sum", 32'(sum), 32'h00);
    chk("mid_rst_cout", 32'(cout), 32'h0);

    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom_range(0, 99) == 0), 8'($urandom), 8'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_8bit
